// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Shared opcodes, FSM state encoding and default widths for the
//             ALU command/result sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 16;

    // op[2] selects the segment, op[1:0] selects the function inside it
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_NOT = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_INC = 3'b110;
    localparam logic [2:0] OP_DEC = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic op_is_arith(input logic [2:0] op);
        return op[2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_flag_gen.sv
`default_nettype none
// ============================================================================
//  Module   : alu_flag_gen
//  Purpose  : Zero / negative / masked-carry flags from the ALU result.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] result_i,
    input  logic             cout_i,
    input  logic             arith_i,
    output logic             zero_o,
    output logic             carry_o,
    output logic             neg_o
);

    assign zero_o  = (result_i == '0);
    assign neg_o   = result_i[WIDTH-1];
    // the logic segment drives cout arbitrarily, so it is never trusted there
    assign carry_o = arith_i & cout_i;

endmodule
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_op_sequencer
//  Purpose  : Valid/ready command and result stage wrapped around an
//             external combinational ALU (one execute cycle per command).
//  Revision : 1.0 - initial release
// ============================================================================
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_s,
    output logic             alu_mode,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_carry,
    output logic             out_neg,
    output logic [CNT_W-1:0] op_count
);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] alu_a_q, alu_b_q, result_q;
    logic [1:0]       alu_s_q;
    logic             alu_mode_q;
    logic             zero_q, carry_q, neg_q;
    logic [CNT_W-1:0] count_q, count_d;

    logic             accept, consume;
    logic             flag_zero, flag_carry, flag_neg;

    // in_ready looks through out_ready so a DONE slot can be refilled in the same edge
    assign in_ready  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
    assign out_valid = (state_q == ST_DONE);
    assign accept    = in_valid & in_ready;
    assign consume   = out_valid & out_ready;
    assign count_d   = count_q + 1'b1;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = in_valid ? ST_EXEC : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    alu_flag_gen #(
        .WIDTH (WIDTH)
    ) u_flag_gen (
        .result_i (alu_result),
        .cout_i   (alu_cout),
        .arith_i  (alu_mode_q),
        .zero_o   (flag_zero),
        .carry_o  (flag_carry),
        .neg_o    (flag_neg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_s_q    <= '0;
            alu_mode_q <= 1'b0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            carry_q    <= 1'b0;
            neg_q      <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                alu_a_q    <= in_a;
                alu_b_q    <= in_b;
                alu_s_q    <= in_op[1:0];
                alu_mode_q <= op_is_arith(in_op);
            end
            // results are written only in EXEC, so DONE holds them untouched
            if (state_q == ST_EXEC) begin
                result_q <= alu_result;
                zero_q   <= flag_zero;
                carry_q  <= flag_carry;
                neg_q    <= flag_neg;
            end
            if (consume) count_q <= count_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_s      = alu_s_q;
    assign alu_mode   = alu_mode_q;
    assign out_result = result_q;
    assign out_zero   = zero_q;
    assign out_carry  = carry_q;
    assign out_neg    = neg_q;
    assign op_count   = count_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_op_sequencer
//  Purpose  : Self-checking bench for alu_op_sequencer with a behavioural ALU.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_op_sequencer;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready;
    logic [2:0] in_op;
    logic [7:0] in_a, in_b;
    logic [7:0] alu_a, alu_b, alu_result;
    logic [1:0] alu_s;
    logic       alu_mode, alu_cout;
    logic [8:0] alu_t;
    logic       out_valid, out_ready;
    logic [7:0] out_result;
    logic       out_zero, out_carry, out_neg;
    logic [15:0] op_count;

    // narrow-counter twin, used to observe counter wrap within a short run
    logic       w4_in_ready, w4_alu_mode, w4_out_valid, w4_out_zero, w4_out_carry, w4_out_neg;
    logic [7:0] w4_alu_a, w4_alu_b, w4_out_result;
    logic [1:0] w4_alu_s;
    logic [3:0] w4_op_count;

    always #5 clk = ~clk;

    alu_op_sequencer #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_mode(alu_mode),
        .alu_result(alu_result), .alu_cout(alu_cout),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_zero(out_zero), .out_carry(out_carry), .out_neg(out_neg),
        .op_count(op_count)
    );

    alu_op_sequencer #(.WIDTH(8), .CNT_W(4)) dut_w4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w4_in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .alu_a(w4_alu_a), .alu_b(w4_alu_b), .alu_s(w4_alu_s), .alu_mode(w4_alu_mode),
        .alu_result(alu_result), .alu_cout(alu_cout),
        .out_valid(w4_out_valid), .out_ready(out_ready), .out_result(w4_out_result),
        .out_zero(w4_out_zero), .out_carry(w4_out_carry), .out_neg(w4_out_neg),
        .op_count(w4_op_count)
    );

    // stand-in ALU; the logic segment deliberately drives cout high
    always_comb begin
        alu_t      = '0;
        alu_result = '0;
        alu_cout   = 1'b1;
        if (!alu_mode) begin
            case (alu_s)
                2'd0:    alu_result = alu_a & alu_b;
                2'd1:    alu_result = alu_a | alu_b;
                2'd2:    alu_result = alu_a ^ alu_b;
                default: alu_result = ~alu_a;
            endcase
        end else begin
            case (alu_s)
                2'd0:    alu_t = {1'b0, alu_a} + {1'b0, alu_b};
                2'd1:    alu_t = {1'b0, alu_a} - {1'b0, alu_b};
                2'd2:    alu_t = {1'b0, alu_a} + 9'd1;
                default: alu_t = {1'b0, alu_a} - 9'd1;
            endcase
            alu_result = alu_t[7:0];
            alu_cout   = alu_t[8];
        end
    end

    typedef struct {
        logic [2:0] op;
        logic [7:0] a, b;
        logic [7:0] r;
        logic       z, c, n;
    } vec_t;

    typedef struct {
        logic [7:0] r;
        logic       z, c, n;
    } res_t;

    vec_t   tbl [8];
    res_t   sb [$];
    int     n_pass = 0;
    int     n_checks = 0;
    int     exp_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // reference: result and carry/borrow straight from the opcode meaning
    function automatic res_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        res_t        e;
        int unsigned ai = a;
        int unsigned bi = b;
        e.c = 1'b0;
        case (op)
            OP_AND:  e.r = a & b;
            OP_OR:   e.r = a | b;
            OP_XOR:  e.r = a ^ b;
            OP_NOT:  e.r = ~a;
            OP_ADD:  begin e.r = 8'((ai + bi) % 256); e.c = (ai + bi) > 255; end
            OP_SUB:  begin e.r = 8'((ai + 256 - bi) % 256); e.c = ai < bi; end
            OP_INC:  begin e.r = 8'((ai + 1) % 256); e.c = (ai == 255); end
            default: begin e.r = 8'((ai + 255) % 256); e.c = (ai == 0); end
        endcase
        e.z = (e.r == 8'h00);
        e.n = e.r[7];
        return e;
    endfunction

    task automatic check_count(input string name);
        check({name, "_cnt"}, 32'(op_count), 32'(exp_count % 65536));
        check({name, "_cnt4"}, 32'(w4_op_count), 32'(exp_count % 16));
    endtask

    task automatic run_one(input vec_t v, input string name);
        @(negedge clk);
        in_valid = 1'b1; in_op = v.op; in_a = v.a; in_b = v.b; out_ready = 1'b1;
        #1 check({name, "_rdy"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check({name, "_exec_valid"}, 32'(out_valid), 32'd0);
        check({name, "_exec_rdy"}, 32'(in_ready), 32'd0);
        check({name, "_alu_bus"}, {12'd0, alu_mode, alu_s, alu_a, alu_b, 1'b0},
              {12'd0, v.op[2], v.op[1:0], v.a, v.b, 1'b0});
        @(negedge clk);
        check({name, "_valid"}, 32'(out_valid), 32'd1);
        check({name, "_result"}, {21'd0, out_result, out_zero, out_carry, out_neg},
              {21'd0, v.r, v.z, v.c, v.n});
        exp_count++;
        @(negedge clk);
        check({name, "_idle"}, 32'(out_valid), 32'd0);
        check_count(name);
    endtask

    task automatic run_stream(input int n_cmds, input bit b2b, input int max_cycles, input string name);
        int   sent = 0, got = 0, cyc = 0, last_acc = -1;
        bit   acc = 0, acc_d1 = 0, acc_d2 = 0, cons;
        res_t e;
        logic [2:0] op;
        logic [7:0] a, b;
        while ((sent < n_cmds || got < sent) && cyc < max_cycles) begin
            @(negedge clk);
            acc_d2 = acc_d1;
            acc_d1 = acc;
            if (acc_d1) check({name, "_exec_valid"}, 32'(out_valid), 32'd0);
            if (acc_d2) check({name, "_lat_valid"}, 32'(out_valid), 32'd1);
            if (out_valid) begin
                if (sb.size() == 0) check({name, "_spurious"}, 32'(out_valid), 32'd0);
                else check({name, "_res"}, {21'd0, out_result, out_zero, out_carry, out_neg},
                           {21'd0, sb[0].r, sb[0].z, sb[0].c, sb[0].n});
            end
            out_ready = b2b ? 1'b1 : 1'($urandom_range(0, 1));
            op = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
            in_valid = (sent < n_cmds) && (b2b || $urandom_range(0, 2) != 0);
            in_op = op; in_a = a; in_b = b;
            #1;
            acc  = in_valid && in_ready;
            cons = out_valid && out_ready;
            if (cons && sb.size() > 0) begin
                void'(sb.pop_front());
                got++;
                exp_count++;
            end
            if (acc) begin
                e = model(op, a, b);
                sb.push_back(e);
                sent++;
                if (b2b && last_acc >= 0) check({name, "_gap"}, 32'(cyc - last_acc), 32'd2);
                last_acc = cyc;
            end
            cyc++;
        end
        check({name, "_done"}, 32'(got), 32'(n_cmds));
        @(negedge clk);
        in_valid = 1'b0;
        check({name, "_drained"}, 32'(out_valid), 32'd0);
        check_count(name);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{OP_AND, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{OP_NOT, 8'h00, 8'h5A, 8'hFF, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{OP_OR,  8'h0F, 8'h80, 8'h8F, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{OP_XOR, 8'hAA, 8'hAA, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{OP_SUB, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b1, 1'b1};
        tbl[6] = '{OP_INC, 8'h7F, 8'h00, 8'h80, 1'b0, 1'b0, 1'b1};
        tbl[7] = '{OP_DEC, 8'h00, 8'h33, 8'hFF, 1'b0, 1'b1, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_outs", {8'd0, out_valid, out_result, out_zero, out_carry, out_neg, alu_mode, alu_s, alu_a},
              32'd0);
        check("rst_cnt", 32'(op_count), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_one(tbl[i], $sformatf("vec%0d", i));

        // result held while the consumer stalls; new commands are refused
        @(negedge clk);
        in_valid = 1'b1; in_op = OP_SUB; in_a = 8'h05; in_b = 8'h07; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            check("hold_state", {22'd0, out_valid, in_ready, out_result},
                  {22'd0, 1'b1, 1'b0, 8'hFE});
            check("hold_flags_bus", {21'd0, out_zero, out_carry, out_neg, alu_a},
                  {21'd0, 1'b0, 1'b1, 1'b1, 8'h05});
            in_valid = 1'b1; in_op = OP_ADD; in_a = 8'($urandom); in_b = 8'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("hold_end", 32'(out_result), 32'h0000_00FE);
        out_ready = 1'b1;
        exp_count++;
        @(negedge clk);
        check("hold_release", 32'(out_valid), 32'd0);
        check_count("hold");

        run_stream(10, 1'b1, 100, "b2b");
        run_stream(200, 1'b0, 5000, "rand");

        // reset while INC is executing discards the pending result
        run_one(tbl[0], "pre_rst");
        @(negedge clk);
        in_valid = 1'b1; in_op = OP_INC; in_a = 8'h7F; in_b = 8'h00; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("rst_exec_bus", 32'(alu_a), 32'h0000_007F);
        #2 rst_n = 1'b0;
        #1;
        exp_count = 0;
        check("rst_async_outs", {8'd0, out_valid, out_result, out_zero, out_carry, out_neg, alu_mode, alu_s, alu_a},
              32'd0);
        check("rst_async_b", 32'(alu_b), 32'd0);
        check_count("rst_async");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_no_valid", 32'(out_valid), 32'd0);
        end
        run_one(tbl[5], "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
